dac_spi_frame_receiver: RTL and testbench
=========================================

// Module: dac_spi_frame_receiver
// PURPOSE
// - Receive-side decoder for the 8-lane DAC SPI bus (DAC_SYNC/DAC_SCLK/DAC_DIN) that main_reduced drives.
// - Oversamples each lane on dataclk and rebuilds every 24-bit frame (6 don't-care, 2 power-down, 16 data bits, MSB first).
// - Presents each recovered 16-bit DAC code with a valid strobe. Flags malformed frames.
// - Used in loopback checks and on-chip self-test of the DAC output path, compared against DAC_output_register_n.
// PARAMETERS
// - NUM_CH      8    number of DAC lanes decoded in parallel
// - FRAME_BITS  24   SCLK falling edges per legal frame
// - ERR_CNT_W   16   width of the saturating frame-error counter
// PORTS
// - dataclk         in   1             system clock; all logic is on its rising edge
// - reset           in   1             synchronous, active-high
// - rx_enable       in   1             1 = decode frames; 0 = lanes held in IDLE, no strobes
// - DAC_SYNC        in   NUM_CH        per-lane frame select, active low
// - DAC_SCLK        in   NUM_CH        per-lane serial clock; data is sampled on its falling edge
// - DAC_DIN         in   NUM_CH        per-lane serial data
// - rx_word         out  16*NUM_CH     last good 16-bit code; lane n is at [16n+15:16n]
// - rx_pd           out  2*NUM_CH      last good power-down bits; lane n is at [2n+1:2n]
// - rx_valid        out  NUM_CH        1-cycle pulse when the lane's rx_word/rx_pd update
// - rx_frame_err    out  NUM_CH        1-cycle pulse when the lane rejects a frame
// - rx_err_count    out  ERR_CNT_W     saturating count of rejected frames, all lanes
// BEHAVIOUR
// - Input stage: SYNC/SCLK/DIN are registered once ("s" stage). sclk_prev holds the previous s-stage SCLK.
//   - fall_n = sclk_prev[n] & ~sclk_s[n]. DIN is taken from the s-stage in the same cycle as fall_n.
// - Per-lane FSM, 2-bit state, 5-bit bit counter bc, 24-bit shift register sr:
//   - IDLE:  sync_s=1 or rx_enable=0. bc<=0. On sync_s=0 with rx_enable=1 -> SHIFT.
//   - SHIFT: on fall_n, sr<={sr[22:0],din_s} and bc<=bc+1.
//     - fall_n arriving when bc==FRAME_BITS -> OVER.
//     - sync_s=1 with bc==FRAME_BITS -> DONE.
//     - sync_s=1 with bc!=FRAME_BITS -> ERR.
//   - OVER:  ignores edges; sync_s=1 -> ERR.
//   - DONE:  one cycle; rx_word<=sr[15:0], rx_pd<=sr[17:16], rx_valid=1; -> IDLE, or SHIFT if sync_s=0.
//   - ERR:   one cycle; rx_frame_err=1; rx_word/rx_pd hold; -> IDLE, or SHIFT if sync_s=0.
// - Latency: rx_valid asserts 2 dataclk cycles after DAC_SYNC rises at the pin (+2 with the macro below).
// - A fall_n in the same cycle as the sync_s rise is ignored, because sync_s=1 takes priority.
// - rx_enable falling mid-frame: the lane returns to IDLE, discards the frame, raises no error.
//   - Re-arming needs a fresh SYNC falling edge while rx_enable=1.
//   - A lane that sees SYNC already low when rx_enable rises waits for SYNC to go high before arming.
// - rx_err_count: +popcount(rx_frame_err) each cycle, saturating at all-ones, never wraps.
// - Lanes are fully independent; simultaneous DONE/ERR on several lanes is legal.
// - Reset mid-frame: all FSMs go to IDLE; rx_word=16'h0000 and rx_pd=2'b00 per lane; rx_valid=0, rx_frame_err=0, rx_err_count=0.
//   - The input and sclk_prev registers reset to 1 (bus idle level), so reset never causes a spurious fall_n.
// CONFIGURATION
// - DAC_RX_SYNC_FF_EN defined:
//   - Two extra flops per input ahead of the s-stage, as a metastability guard for asynchronous or off-board sources.
//   - Latency grows by 2 cycles.
//   - Minimum SCLK high/low time is 2 dataclk cycles, unchanged.
// - Not defined: s-stage only. Legal only when the source is on dataclk, as the on-chip main_reduced loopback is.
// TESTING
// - Lane 0 sends pd=00, data 16'h8000, 24 edges -> rx_word[15:0]=16'h8000, rx_valid[0]=1 for exactly 1 cycle, 2 cycles after SYNC rises.
// - Lane 2 sends pd=11, data 16'h77BA -> rx_pd[5:4]=2'b11, rx_word[47:32]=16'h77BA; other lanes show no strobe.
// - Lane 1 sends 23 edges, then 25 edges -> two rx_frame_err[1] pulses, rx_word[31:16] unchanged, rx_err_count=2.
// - reset at edge 12 of a lane-0 frame, then a clean frame 16'h1234 -> no strobe for the cut frame, then rx_word=16'h1234.
// - rx_enable=0 during frame 16'hFFFF, then =1 before frame 16'h0001 -> only 16'h0001 is reported; error count stays 0.
// - Force ERR_CNT_W=2, send 5 short frames on all 8 lanes at once -> rx_err_count sticks at 2'b11.

Source files
------------

// File: rtl/dac_spi_frame_receiver.sv
// Receive-side decoder for the 8-lane DAC SPI bus: rebuilds 24-bit frames per lane, strobes codes, counts bad frames.
// Define DAC_RX_SYNC_FF_EN to add a two-flop synchronizer ahead of the input stage (latency +2 cycles).

module dac_spi_frame_receiver_lane #(
    parameter int FRAME_BITS = 24
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_enable,
    input  logic        i_sync_s,
    input  logic        i_sync_prev,
    input  logic        i_fall,
    input  logic        i_din_s,
    output logic [15:0] o_word,
    output logic [1:0]  o_pd,
    output logic        o_valid,
    output logic        o_err
);
    localparam int BC_W = $clog2(FRAME_BITS + 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(FRAME_BITS);
    // Only pd + data are ever observed, so the leading don't-care bits simply shift out the top.
    localparam int SR_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [BC_W-1:0]   r_bc, w_bc_nxt;
    logic [SR_W-1:0]   r_sr, w_sr_nxt;
    logic [15:0]       r_word;
    logic [1:0]        r_pd;
    logic              r_valid, r_err;
    logic              w_done, w_err;

    // The DONE/ERR cycle is the registered strobe cycle; the lane is already back in IDLE then,
    // which ignores SCLK and re-arms only on a fresh SYNC falling edge.
    always_comb begin
        w_state_nxt = r_state;
        w_bc_nxt    = r_bc;
        w_sr_nxt    = r_sr;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_bc_nxt = '0;
                if (i_rx_enable && !i_sync_s && i_sync_prev)
                    w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!i_rx_enable) begin
                    w_state_nxt = ST_IDLE;
                    w_bc_nxt    = '0;
                end else if (i_sync_s) begin
                    w_state_nxt = ST_IDLE;
                    w_bc_nxt    = '0;
                    w_done      = (r_bc == BC_FULL);
                    w_err       = (r_bc != BC_FULL);
                end else if (i_fall) begin
                    if (r_bc == BC_FULL) begin
                        w_state_nxt = ST_OVER;
                    end else begin
                        w_sr_nxt = {r_sr[SR_W-2:0], i_din_s};
                        w_bc_nxt = r_bc + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                w_bc_nxt = '0;
                if (!i_rx_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_sync_s) begin
                    w_state_nxt = ST_IDLE;
                    w_err       = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_bc    <= '0;
            r_sr    <= '0;
            r_word  <= '0;
            r_pd    <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bc    <= w_bc_nxt;
            r_sr    <= w_sr_nxt;
            r_valid <= w_done;
            r_err   <= w_err;
            if (w_done) begin
                r_word <= r_sr[15:0];
                r_pd   <= r_sr[17:16];
            end
        end
    end

    assign o_word  = r_word;
    assign o_pd    = r_pd;
    assign o_valid = r_valid;
    assign o_err   = r_err;
endmodule

module dac_spi_frame_receiver #(
    parameter int NUM_CH     = 8,
    parameter int FRAME_BITS = 24,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                   dataclk,
    input  logic                   reset,
    input  logic                   rx_enable,
    input  logic [NUM_CH-1:0]      DAC_SYNC,
    input  logic [NUM_CH-1:0]      DAC_SCLK,
    input  logic [NUM_CH-1:0]      DAC_DIN,
    output logic [16*NUM_CH-1:0]   rx_word,
    output logic [2*NUM_CH-1:0]    rx_pd,
    output logic [NUM_CH-1:0]      rx_valid,
    output logic [NUM_CH-1:0]      rx_frame_err,
    output logic [ERR_CNT_W-1:0]   rx_err_count
);
    localparam int PC_W  = $clog2(NUM_CH + 1);
    localparam int SUM_W = ERR_CNT_W + PC_W;

    logic [NUM_CH-1:0] w_sync_pre, w_sclk_pre, w_din_pre;
    logic [NUM_CH-1:0] r_sync_s, r_sclk_s, r_din_s, r_sclk_prev, r_sync_prev;
    logic [NUM_CH-1:0] w_fall;

`ifdef DAC_RX_SYNC_FF_EN
    logic [NUM_CH-1:0] r_sync_m1, r_sclk_m1, r_din_m1;
    logic [NUM_CH-1:0] r_sync_m2, r_sclk_m2, r_din_m2;

    always_ff @(posedge dataclk) begin
        if (reset) begin
            r_sync_m1 <= '1;
            r_sclk_m1 <= '1;
            r_din_m1  <= '1;
            r_sync_m2 <= '1;
            r_sclk_m2 <= '1;
            r_din_m2  <= '1;
        end else begin
            r_sync_m1 <= DAC_SYNC;
            r_sclk_m1 <= DAC_SCLK;
            r_din_m1  <= DAC_DIN;
            r_sync_m2 <= r_sync_m1;
            r_sclk_m2 <= r_sclk_m1;
            r_din_m2  <= r_din_m1;
        end
    end

    assign w_sync_pre = r_sync_m2;
    assign w_sclk_pre = r_sclk_m2;
    assign w_din_pre  = r_din_m2;
`else
    assign w_sync_pre = DAC_SYNC;
    assign w_sclk_pre = DAC_SCLK;
    assign w_din_pre  = DAC_DIN;
`endif

    // Idle-level reset values keep reset from looking like an SCLK or SYNC edge.
    always_ff @(posedge dataclk) begin
        if (reset) begin
            r_sync_s    <= '1;
            r_sclk_s    <= '1;
            r_din_s     <= '1;
            r_sclk_prev <= '1;
            r_sync_prev <= '1;
        end else begin
            r_sync_s    <= w_sync_pre;
            r_sclk_s    <= w_sclk_pre;
            r_din_s     <= w_din_pre;
            r_sclk_prev <= r_sclk_s;
            r_sync_prev <= r_sync_s;
        end
    end

    assign w_fall = r_sclk_prev & ~r_sclk_s;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        dac_spi_frame_receiver_lane #(
            .FRAME_BITS(FRAME_BITS)
        ) u_lane (
            .i_clk       (dataclk),
            .i_reset     (reset),
            .i_rx_enable (rx_enable),
            .i_sync_s    (r_sync_s[n]),
            .i_sync_prev (r_sync_prev[n]),
            .i_fall      (w_fall[n]),
            .i_din_s     (r_din_s[n]),
            .o_word      (rx_word[16*n +: 16]),
            .o_pd        (rx_pd[2*n +: 2]),
            .o_valid     (rx_valid[n]),
            .o_err       (rx_frame_err[n])
        );
    end

    logic [ERR_CNT_W-1:0] r_err_count;
    logic [PC_W-1:0]      w_pop;
    logic [SUM_W-1:0]     w_sum;

    always_comb begin
        w_pop = '0;
        for (int n = 0; n < NUM_CH; n++)
            w_pop = w_pop + PC_W'(rx_frame_err[n]);
        w_sum = SUM_W'(r_err_count) + SUM_W'(w_pop);
    end

    // The sum is wide enough never to wrap, so any carry above ERR_CNT_W means saturate.
    always_ff @(posedge dataclk) begin
        if (reset)
            r_err_count <= '0;
        else if (|w_sum[SUM_W-1:ERR_CNT_W])
            r_err_count <= '1;
        else
            r_err_count <= w_sum[ERR_CNT_W-1:0];
    end

    assign rx_err_count = r_err_count;
endmodule

// File: tb/tb_dac_spi_frame_receiver.sv
// Self-checking bench for dac_spi_frame_receiver: bus-level frame driver plus a frame-outcome reference model.
module tb_dac_spi_frame_receiver;
    localparam int NUM_CH = 8;
`ifdef DAC_RX_SYNC_FF_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic                  dataclk = 1'b0;
    logic                  reset = 1'b1;
    logic                  rx_enable = 1'b1;
    logic [NUM_CH-1:0]     DAC_SYNC = '1;
    logic [NUM_CH-1:0]     DAC_SCLK = '1;
    logic [NUM_CH-1:0]     DAC_DIN = '0;
    logic [16*NUM_CH-1:0]  rx_word, rx_word2;
    logic [2*NUM_CH-1:0]   rx_pd, rx_pd2;
    logic [NUM_CH-1:0]     rx_valid, rx_valid2, rx_frame_err, rx_frame_err2;
    logic [15:0]           rx_err_count;
    logic [1:0]            rx_err_count2;

    dac_spi_frame_receiver dut (
        .dataclk(dataclk), .reset(reset), .rx_enable(rx_enable),
        .DAC_SYNC(DAC_SYNC), .DAC_SCLK(DAC_SCLK), .DAC_DIN(DAC_DIN),
        .rx_word(rx_word), .rx_pd(rx_pd), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .rx_err_count(rx_err_count)
    );

    dac_spi_frame_receiver #(.ERR_CNT_W(2)) dut2 (
        .dataclk(dataclk), .reset(reset), .rx_enable(rx_enable),
        .DAC_SYNC(DAC_SYNC), .DAC_SCLK(DAC_SCLK), .DAC_DIN(DAC_DIN),
        .rx_word(rx_word2), .rx_pd(rx_pd2), .rx_valid(rx_valid2),
        .rx_frame_err(rx_frame_err2), .rx_err_count(rx_err_count2)
    );

    always #5 dataclk = ~dataclk;

    int tests = 0, fails = 0, cyc = 0;
    int vcnt[NUM_CH] = '{default: 0};
    int ecnt[NUM_CH] = '{default: 0};
    int vcyc[NUM_CH] = '{default: -1};
    int v0[NUM_CH], e0[NUM_CH];
    int vtot2 = 0, etot2 = 0, vt0 = 0, et0 = 0;

    logic [23:0] f_data[NUM_CH];
    int          f_n[NUM_CH];
    logic [15:0] exp_word[NUM_CH];
    logic [1:0]  exp_pd[NUM_CH];
    int          exp_v[NUM_CH], exp_e[NUM_CH];
    int          exp_cnt = 0;

    always @(posedge dataclk) cyc <= cyc + 1;

    always @(negedge dataclk) begin
        for (int n = 0; n < NUM_CH; n++) begin
            if (rx_valid[n]) begin
                vcnt[n]++;
                vcyc[n] = cyc;
            end
            if (rx_frame_err[n]) ecnt[n]++;
            if (rx_valid2[n]) vtot2++;
            if (rx_frame_err2[n]) etot2++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge dataclk);
        #1;
    endtask

    task automatic snap();
        for (int n = 0; n < NUM_CH; n++) begin
            v0[n] = vcnt[n];
            e0[n] = ecnt[n];
        end
        vt0 = vtot2;
        et0 = etot2;
    endtask

    function automatic void model_clear();
        for (int n = 0; n < NUM_CH; n++) begin
            exp_word[n] = '0;
            exp_pd[n]   = '0;
        end
        exp_cnt = 0;
    endfunction

    // A frame is good exactly when its lane saw FRAME_BITS edges; everything else is one error.
    function automatic void model_frame(input logic [NUM_CH-1:0] mask, input bit aborted);
        for (int n = 0; n < NUM_CH; n++) begin
            exp_v[n] = 0;
            exp_e[n] = 0;
            if (mask[n] && !aborted) begin
                if (f_n[n] == 24) begin
                    exp_v[n]    = 1;
                    exp_word[n] = f_data[n][15:0];
                    exp_pd[n]   = f_data[n][17:16];
                end else begin
                    exp_e[n] = 1;
                    exp_cnt  = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
                end
            end
        end
    endfunction

    // cut_kind: 0 none, 1 reset at edge cut_at, 2 rx_enable drops, 3 rx_enable rises
    task automatic drive_frame(input logic [NUM_CH-1:0] mask, input int cut_at,
                               input int cut_kind, output int rise_cyc);
        int maxn = 0;
        bit stop = 0;
        rise_cyc = -1;
        for (int n = 0; n < NUM_CH; n++)
            if (mask[n] && f_n[n] > maxn) maxn = f_n[n];
        DAC_SYNC = ~mask;
        DAC_SCLK = '1;
        tick(2);
        for (int e = 0; e < maxn && !stop; e++) begin
            if (e == cut_at) begin
                case (cut_kind)
                    1: begin
                        DAC_SYNC = '1;
                        DAC_SCLK = '1;
                        reset = 1'b1;
                        tick(2);
                        reset = 1'b0;
                        tick(2);
                        stop = 1;
                    end
                    2: rx_enable = 1'b0;
                    3: rx_enable = 1'b1;
                    default: ;
                endcase
            end
            if (!stop) begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (mask[n] && e < f_n[n]) begin
                        DAC_SCLK[n] = 1'b0;
                        DAC_DIN[n]  = (e < 24) ? f_data[n][23-e] : 1'b0;
                    end
                end
                tick(2);
                DAC_SCLK = '1;
                tick(2);
            end
        end
        if (!stop) begin
            DAC_SYNC = '1;
            rise_cyc = cyc;
        end
        tick(6);
    endtask

    task automatic reset_dut();
        DAC_SYNC = '1;
        DAC_SCLK = '1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        tests++; if (rx_word !== '0) begin fails++; $display("FAIL reset_word: got %h want 0", rx_word); end
        tests++; if (rx_pd !== '0) begin fails++; $display("FAIL reset_pd: got %h want 0", rx_pd); end
        tests++; if (rx_valid !== '0) begin fails++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        tests++; if (rx_frame_err !== '0) begin fails++; $display("FAIL reset_err: got %b want 0", rx_frame_err); end
        tests++; if (rx_err_count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", rx_err_count); end
        reset = 1'b0;
        tick(3);
        model_clear();
        tests++; if (rx_valid !== '0 || rx_frame_err !== '0) begin
            fails++; $display("FAIL reset_release: got valid=%b err=%b want 0", rx_valid, rx_frame_err);
        end
    endtask

    // Directed single-lane frames: lane0 8000, lane2 77BA with pd=11, lane1 short then long.
    task automatic test_directed();
        int rc;
        logic [NUM_CH-1:0] mask;
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: begin mask = 8'h01; f_n[0] = 24; f_data[0] = {6'h2A, 2'b00, 16'h8000}; end
                1: begin mask = 8'h04; f_n[2] = 24; f_data[2] = {6'h15, 2'b11, 16'h77BA}; end
                2: begin mask = 8'h02; f_n[1] = 23; f_data[1] = 24'($urandom); end
                default: begin mask = 8'h02; f_n[1] = 25; f_data[1] = 24'($urandom); end
            endcase
            snap();
            drive_frame(mask, -1, 0, rc);
            model_frame(mask, 0);
            for (int n = 0; n < NUM_CH; n++) begin
                tests++;
                if ((vcnt[n] - v0[n]) !== exp_v[n] || (ecnt[n] - e0[n]) !== exp_e[n] ||
                    rx_word[16*n +: 16] !== exp_word[n] || rx_pd[2*n +: 2] !== exp_pd[n]) begin
                    fails++;
                    $display("FAIL directed step%0d lane%0d: got v=%0d e=%0d word=%h pd=%b, want v=%0d e=%0d word=%h pd=%b",
                             s, n, vcnt[n] - v0[n], ecnt[n] - e0[n], rx_word[16*n +: 16], rx_pd[2*n +: 2],
                             exp_v[n], exp_e[n], exp_word[n], exp_pd[n]);
                end
            end
            tests++;
            if (rx_err_count !== 16'(exp_cnt)) begin
                fails++; $display("FAIL directed step%0d count: got %0d want %0d", s, rx_err_count, exp_cnt);
            end
            if (s == 0) begin
                tests++;
                if (vcyc[0] !== rc + LAT) begin
                    fails++; $display("FAIL latency: valid at cycle %0d, want %0d", vcyc[0], rc + LAT);
                end
            end
        end
    endtask

    // Step 0 is cut by reset at edge 12; step 1 is a clean 1234 frame afterwards.
    task automatic test_reset_midframe();
        int rc;
        for (int s = 0; s < 2; s++) begin
            f_n[0] = 24;
            f_data[0] = (s == 0) ? 24'($urandom) : {8'h00, 16'h1234};
            snap();
            drive_frame(8'h01, (s == 0) ? 12 : -1, (s == 0) ? 1 : 0, rc);
            if (s == 0) model_clear();
            model_frame(8'h01, s == 0);
            for (int n = 0; n < NUM_CH; n++) begin
                tests++;
                if ((vcnt[n] - v0[n]) !== exp_v[n] || (ecnt[n] - e0[n]) !== exp_e[n] ||
                    rx_word[16*n +: 16] !== exp_word[n] || rx_pd[2*n +: 2] !== exp_pd[n]) begin
                    fails++;
                    $display("FAIL reset_midframe step%0d lane%0d: got v=%0d e=%0d word=%h pd=%b, want v=%0d e=%0d word=%h pd=%b",
                             s, n, vcnt[n] - v0[n], ecnt[n] - e0[n], rx_word[16*n +: 16], rx_pd[2*n +: 2],
                             exp_v[n], exp_e[n], exp_word[n], exp_pd[n]);
                end
            end
            tests++;
            if (rx_err_count !== 16'(exp_cnt)) begin
                fails++; $display("FAIL reset_midframe step%0d count: got %0d want %0d", s, rx_err_count, exp_cnt);
            end
        end
    endtask

    // Steps: disabled FFFF, enabled 0001, enable drop mid-frame, enable rise with SYNC low, clean re-arm.
    task automatic test_enable();
        int rc;
        bit aborted;
        reset_dut();
        for (int s = 0; s < 5; s++) begin
            f_n[0] = 24;
            aborted = (s == 0 || s == 2 || s == 3);
            case (s)
                0: f_data[0] = {8'h00, 16'hFFFF};
                1: f_data[0] = {8'h00, 16'h0001};
                default: f_data[0] = 24'($urandom);
            endcase
            rx_enable = (s == 0 || s == 3) ? 1'b0 : 1'b1;
            tick(2);
            snap();
            drive_frame(8'h01, (s == 2) ? 10 : (s == 3) ? 8 : -1, (s == 2) ? 2 : (s == 3) ? 3 : 0, rc);
            model_frame(8'h01, aborted);
            for (int n = 0; n < NUM_CH; n++) begin
                tests++;
                if ((vcnt[n] - v0[n]) !== exp_v[n] || (ecnt[n] - e0[n]) !== exp_e[n] ||
                    rx_word[16*n +: 16] !== exp_word[n] || rx_pd[2*n +: 2] !== exp_pd[n]) begin
                    fails++;
                    $display("FAIL enable step%0d lane%0d: got v=%0d e=%0d word=%h pd=%b, want v=%0d e=%0d word=%h pd=%b",
                             s, n, vcnt[n] - v0[n], ecnt[n] - e0[n], rx_word[16*n +: 16], rx_pd[2*n +: 2],
                             exp_v[n], exp_e[n], exp_word[n], exp_pd[n]);
                end
            end
            tests++;
            if (rx_err_count !== 16'(exp_cnt)) begin
                fails++; $display("FAIL enable step%0d count: got %0d want %0d", s, rx_err_count, exp_cnt);
            end
        end
        rx_enable = 1'b1;
        tick(2);
    endtask

    task automatic test_random();
        int rc;
        logic [NUM_CH-1:0] mask;
        for (int it = 0; it < 25; it++) begin
            mask = NUM_CH'($urandom_range(1, 255));
            for (int n = 0; n < NUM_CH; n++) begin
                f_data[n] = 24'($urandom);
                case ($urandom_range(0, 3))
                    0, 1: f_n[n] = 24;
                    2: f_n[n] = $urandom_range(20, 28);
                    default: f_n[n] = $urandom_range(0, 31);
                endcase
            end
            snap();
            drive_frame(mask, -1, 0, rc);
            model_frame(mask, 0);
            for (int n = 0; n < NUM_CH; n++) begin
                tests++;
                if ((vcnt[n] - v0[n]) !== exp_v[n] || (ecnt[n] - e0[n]) !== exp_e[n] ||
                    rx_word[16*n +: 16] !== exp_word[n] || rx_pd[2*n +: 2] !== exp_pd[n]) begin
                    fails++;
                    $display("FAIL random it%0d lane%0d: got v=%0d e=%0d word=%h pd=%b, want v=%0d e=%0d word=%h pd=%b",
                             it, n, vcnt[n] - v0[n], ecnt[n] - e0[n], rx_word[16*n +: 16], rx_pd[2*n +: 2],
                             exp_v[n], exp_e[n], exp_word[n], exp_pd[n]);
                end
            end
            tests++;
            if (rx_err_count !== 16'(exp_cnt)) begin
                fails++; $display("FAIL random it%0d count: got %0d want %0d", it, rx_err_count, exp_cnt);
            end
        end
    endtask

    // Five all-lane short frames: 40 errors, the 2-bit counter must stick at 3.
    task automatic test_saturation();
        int rc;
        int et_start;
        reset_dut();
        et_start = etot2;
        for (int k = 0; k < 5; k++) begin
            for (int n = 0; n < NUM_CH; n++) begin
                f_n[n] = 20;
                f_data[n] = 24'($urandom);
            end
            snap();
            drive_frame(8'hFF, -1, 0, rc);
            model_frame(8'hFF, 0);
            tests++;
            if (rx_err_count !== 16'(exp_cnt)) begin
                fails++; $display("FAIL sat frame%0d count16: got %0d want %0d", k, rx_err_count, exp_cnt);
            end
            tests++;
            if (rx_err_count2 !== 2'((exp_cnt > 3) ? 3 : exp_cnt)) begin
                fails++; $display("FAIL sat frame%0d count2: got %0d want %0d", k, rx_err_count2,
                                  (exp_cnt > 3) ? 3 : exp_cnt);
            end
            tests++;
            if ((etot2 - et0) !== 8 || (vtot2 - vt0) !== 0) begin
                fails++; $display("FAIL sat frame%0d strobes2: got err=%0d valid=%0d want err=8 valid=0",
                                  k, etot2 - et0, vtot2 - vt0);
            end
        end
        tests++;
        if ((etot2 - et_start) !== 40 || rx_word2 !== '0 || rx_pd2 !== '0) begin
            fails++; $display("FAIL sat total: got err=%0d word=%h pd=%h want err=40 word=0 pd=0",
                              etot2 - et_start, rx_word2, rx_pd2);
        end
    endtask

    initial begin
        for (int n = 0; n < NUM_CH; n++) begin
            f_data[n] = '0;
            f_n[n]    = 24;
        end
        model_clear();
        test_reset();
        test_directed();
        test_reset_midframe();
        test_enable();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
